// File: rtl/bg_deduction_seq.sv
// bg_deduction_seq: transmit-side sequencer for background deduction.
// Once accumulation finishes it reads the first BG_BINS RAM bins and averages
// them into a background level. It then streams all POINTS bins with that
// level subtracted, saturating at zero. Finally it waits for the downstream
// monitor's completion pulse, or times out.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              one-cycle pulse, begin a frame (honoured only in IDLE)
//   rd_en, rd_addr     RAM read request
//   rd_data            RAM read data, valid RD_LAT cycles after rd_en
//   BG_Deduction_EN    enable to the downstream monitor (STREAM..WAIT_DONE)
//   data_out           background-subtracted bin
//   data_valid_out     data_out qualifier, one contiguous POINTS-long burst
//   BG_Deduction_Done  completion pulse from downstream (honoured in WAIT_DONE)
//   bg_value           background mean latched for the current frame
//   busy               state != IDLE
//   done               one-cycle frame-complete pulse
//   err_timeout        sticky, set when Done is not returned within TIMEOUT
module bg_deduction_seq #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 9,
    parameter int unsigned POINTS  = 512,
    parameter int unsigned BG_LOG2 = 4,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          BG_Deduction_EN,
    output logic [DW-1:0] data_out,
    output logic          data_valid_out,
    input  logic          BG_Deduction_Done,
    output logic [DW-1:0] bg_value,
    output logic          busy,
    output logic          done,
    output logic          err_timeout
);

    localparam int unsigned BG_BINS = 1 << BG_LOG2;
    localparam int unsigned SW      = DW + BG_LOG2;
    localparam int unsigned TW      = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BG_RD,
        S_BG_WAIT,
        S_STREAM,
        S_DRAIN,
        S_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [DW-1:0]     bg_q, bg_d;
    logic              en_q, en_d;
    logic [DW-1:0]     dout_q, dout_d;
    logic              dv_q, dv_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              rd_vld;

    // Read-valid delay line: bit RD_LAT-1 marks rd_data as valid this cycle.
    assign vld_d  = (vld_q << 1) | RD_LAT'(rd_en_q);
    assign rd_vld = vld_q[RD_LAT-1];

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            vld_q   <= '0;
            sum_q   <= '0;
            bg_q    <= '0;
            en_q    <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            sum_q   <= sum_d;
            bg_q    <= bg_d;
            en_q    <= en_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        sum_d   = sum_q;
        bg_d    = bg_q;
        en_d    = en_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        tmo_d   = '0;
        done_d  = 1'b0;
        err_d   = err_q;

        // Background reads may still be landing after the last one is issued.
        if (rd_vld && (state_q == S_BG_RD || state_q == S_BG_WAIT)) begin
            sum_d = sum_q + SW'(rd_data);
        end

        // Stream reads land in STREAM and, for the tail, in DRAIN.
        if (rd_vld && (state_q == S_STREAM || state_q == S_DRAIN)) begin
            dv_d   = 1'b1;
            dout_d = (rd_data > bg_q) ? (rd_data - bg_q) : '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BG_RD;
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                end
            end
            S_BG_RD: begin
                if (addr_q == AW'(BG_BINS - 1)) begin
                    state_d = S_BG_WAIT;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + AW'(1);
                end
            end
            S_BG_WAIT: begin
                // Empty delay line means the final background word is in sum_q.
                if (vld_q == '0) begin
                    bg_d    = DW'(sum_q >> BG_LOG2);
                    sum_d   = '0;
                    state_d = S_STREAM;
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                    en_d    = 1'b1;
                end
            end
            S_STREAM: begin
                if (addr_q == AW'(POINTS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // Last valid is on data_out now; it drops as we leave.
                if (vld_q == '0) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (BG_Deduction_Done) begin
                    done_d  = 1'b1;
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign rd_en           = rd_en_q;
    assign rd_addr         = addr_q;
    assign BG_Deduction_EN = en_q;
    assign data_out        = dout_q;
    assign data_valid_out  = dv_q;
    assign bg_value        = bg_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_timeout     = err_q;

endmodule

// File: tb/tb_bg_deduction_seq.sv
// Directed bench for bg_deduction_seq. Instance 0 has RD_LAT=2, instance 1
// has RD_LAT=1 and instance 2 has RD_LAT=4. All use POINTS=64, BG_LOG2=4 and
// TIMEOUT=64. Every instance has its own RAM pipeline and monitor model, and
// all of them read one shared memory image.
module tb_bg_deduction_seq;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [2:0]  start_v    = '0;
    logic        mon_en     = 1'b1;
    logic        stray_done = 1'b0;
    int          cyc        = 0;
    int          checks     = 0;
    int          errors     = 0;
    logic [31:0] mem [0:511];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        logic        s_rd_en, s_en, s_dv, s_busy, s_done, s_err, done_in;
        logic [8:0]  s_rd_addr;
        logic [31:0] s_rd_data, s_dout, s_bg;
        logic [31:0] pipe [0:LAT-1];
        logic        d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
        logic        rd_en_p = 1'b0, dv_p = 1'b0, err_p = 1'b0;
        int          last_rd_rise = 0, last_dv_rise = 0, last_dv_fall = 0;
        int          last_done = 0, last_err_rise = 0;
        int          run_len = 0, last_run_len = 0, n_dv = 0, n_done = 0;
        logic [31:0] q [$];

        bg_deduction_seq #(
            .DW(32), .AW(9), .POINTS(64), .BG_LOG2(4), .RD_LAT(LAT), .TIMEOUT(64)
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .start             (start_v[g]),
            .rd_en             (s_rd_en),
            .rd_addr           (s_rd_addr),
            .rd_data           (s_rd_data),
            .BG_Deduction_EN   (s_en),
            .data_out          (s_dout),
            .data_valid_out    (s_dv),
            .BG_Deduction_Done (done_in),
            .bg_value          (s_bg),
            .busy              (s_busy),
            .done              (s_done),
            .err_timeout       (s_err)
        );

        // RAM with LAT-cycle read latency, and a monitor that pulses Done
        // two cycles after data_valid_out falls.
        always @(posedge clk) begin
            pipe[0] <= s_rd_en ? mem[s_rd_addr] : 32'h0;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            d1 <= s_dv;
            d2 <= d1;
            d3 <= d2;
        end
        assign s_rd_data = pipe[LAT-1];

        if (g == 0) begin : g_main
            assign done_in = (mon_en & d3 & ~d2) | stray_done;
        end else begin : g_lat
            assign done_in = d3 & ~d2;
        end

        // Event recorder, sampled on the falling edge.
        always @(negedge clk) begin
            if (s_rd_en && !rd_en_p && s_en) last_rd_rise <= cyc;
            if (s_dv) begin
                q.push_back(s_dout);
                n_dv    <= n_dv + 1;
                run_len <= (dv_p ? run_len : 0) + 1;
                if (!dv_p) last_dv_rise <= cyc;
            end else begin
                if (dv_p) begin
                    last_dv_fall <= cyc;
                    last_run_len <= run_len;
                end
                run_len <= 0;
            end
            if (s_done) begin
                last_done <= cyc;
                n_done    <= n_done + 1;
            end
            if (s_err && !err_p) last_err_rise <= cyc;
            rd_en_p <= s_rd_en;
            dv_p    <= s_dv;
            err_p   <= s_err;
        end
    end

    task automatic run_frame(output bit ok);
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (gi[0].s_done) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic load_flat();
        for (int i = 0; i < 64; i++) mem[i] = (i < 16) ? 32'd100 : 32'(100 + i);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (gi[0].s_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%0b want=0", gi[0].s_rd_en); end
        checks++; if (gi[0].s_rd_addr !== 9'd0) begin errors++; $display("FAIL reset_rd_addr got=%0d want=0", gi[0].s_rd_addr); end
        checks++; if (gi[0].s_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%0b want=0", gi[0].s_en); end
        checks++; if (gi[0].s_dv !== 1'b0) begin errors++; $display("FAIL reset_dv got=%0b want=0", gi[0].s_dv); end
        checks++; if (gi[0].s_dout !== 32'd0) begin errors++; $display("FAIL reset_dout got=%0h want=0", gi[0].s_dout); end
        checks++; if (gi[0].s_bg !== 32'd0) begin errors++; $display("FAIL reset_bg got=%0h want=0", gi[0].s_bg); end
        checks++; if ({gi[0].s_busy, gi[0].s_done, gi[0].s_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {gi[0].s_busy, gi[0].s_done, gi[0].s_err}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flat();
        bit ok; int base; int n0; int nd0; logic [31:0] exp;
        load_flat();
        base = gi[0].q.size(); n0 = gi[0].n_dv; nd0 = gi[0].n_done;
        run_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL flat_done got=0 want=1"); end
        checks++; if (gi[0].s_bg !== 32'd100) begin errors++; $display("FAIL flat_bg got=%0d want=100", gi[0].s_bg); end
        checks++; if (gi[0].n_dv - n0 != 64) begin errors++; $display("FAIL flat_count got=%0d want=64", gi[0].n_dv - n0); end
        checks++; if (gi[0].last_run_len != 64) begin errors++; $display("FAIL flat_contig got=%0d want=64", gi[0].last_run_len); end
        for (int i = 0; i < 64; i++) begin
            exp = (i < 16) ? 32'd0 : 32'(i);
            checks++;
            if (gi[0].q[base+i] !== exp) begin errors++; $display("FAIL flat_bin%0d got=%0d want=%0d", i, gi[0].q[base+i], exp); end
        end
        checks++; if (gi[0].last_done - gi[0].last_dv_fall != 3) begin errors++; $display("FAIL flat_done_lat got=%0d want=3", gi[0].last_done - gi[0].last_dv_fall); end
        checks++; if (gi[0].n_done - nd0 != 1) begin errors++; $display("FAIL flat_done_cnt got=%0d want=1", gi[0].n_done - nd0); end
        checks++; if ({gi[0].s_en, gi[0].s_busy, gi[0].s_err} !== 3'b000) begin errors++; $display("FAIL flat_idle got=%b want=000", {gi[0].s_en, gi[0].s_busy, gi[0].s_err}); end
    endtask

    task automatic test_saturation();
        bit ok; int base;
        for (int i = 0; i < 64; i++) mem[i] = (i < 16) ? 32'(7 + i) : 32'(1000 + i);
        mem[20] = 32'd10;
        mem[21] = 32'hFFFF_FFFF;
        base = gi[0].q.size();
        run_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_done got=0 want=1"); end
        checks++; if (gi[0].s_bg !== 32'd14) begin errors++; $display("FAIL sat_bg got=%0d want=14", gi[0].s_bg); end
        checks++; if (gi[0].q[base+0] !== 32'd0) begin errors++; $display("FAIL sat_bin0 got=%0h want=0", gi[0].q[base+0]); end
        checks++; if (gi[0].q[base+14] !== 32'd7) begin errors++; $display("FAIL sat_bin14 got=%0h want=7", gi[0].q[base+14]); end
        checks++; if (gi[0].q[base+15] !== 32'd8) begin errors++; $display("FAIL sat_bin15 got=%0h want=8", gi[0].q[base+15]); end
        checks++; if (gi[0].q[base+20] !== 32'd0) begin errors++; $display("FAIL sat_bin20 got=%0h want=0", gi[0].q[base+20]); end
        checks++; if (gi[0].q[base+21] !== 32'hFFFF_FFF1) begin errors++; $display("FAIL sat_bin21 got=%0h want=fffffff1", gi[0].q[base+21]); end
        checks++; if (gi[0].q[base+40] !== 32'd1026) begin errors++; $display("FAIL sat_bin40 got=%0d want=1026", gi[0].q[base+40]); end
        checks++; if (gi[0].q[base+63] !== 32'd1049) begin errors++; $display("FAIL sat_bin63 got=%0d want=1049", gi[0].q[base+63]); end
    endtask

    task automatic test_latency();
        bit s1 = 1'b0, s2 = 1'b0; int b2; int n1; int n2;
        b2 = gi[2].q.size(); n1 = gi[1].n_dv; n2 = gi[2].n_dv;
        @(negedge clk); start_v = 3'b110;
        @(negedge clk); start_v = 3'b000;
        for (int i = 0; i < 400 && !(s1 && s2); i++) begin
            @(negedge clk);
            if (gi[1].s_done) s1 = 1'b1;
            if (gi[2].s_done) s2 = 1'b1;
        end
        repeat (2) @(negedge clk);
        checks++; if (!(s1 && s2)) begin errors++; $display("FAIL lat_done got=%b want=11", {s1, s2}); end
        checks++; if (gi[1].last_dv_rise - gi[1].last_rd_rise != 2) begin errors++; $display("FAIL lat1_first got=%0d want=2", gi[1].last_dv_rise - gi[1].last_rd_rise); end
        checks++; if (gi[2].last_dv_rise - gi[2].last_rd_rise != 5) begin errors++; $display("FAIL lat4_first got=%0d want=5", gi[2].last_dv_rise - gi[2].last_rd_rise); end
        checks++; if (gi[1].last_run_len != 64 || gi[1].n_dv - n1 != 64) begin errors++; $display("FAIL lat1_contig got=%0d want=64", gi[1].last_run_len); end
        checks++; if (gi[2].last_run_len != 64 || gi[2].n_dv - n2 != 64) begin errors++; $display("FAIL lat4_contig got=%0d want=64", gi[2].last_run_len); end
        checks++; if (gi[1].s_bg !== 32'd14 || gi[2].s_bg !== 32'd14) begin errors++; $display("FAIL lat_bg got=%0d,%0d want=14", gi[1].s_bg, gi[2].s_bg); end
        checks++; if (gi[2].q[b2+21] !== 32'hFFFF_FFF1) begin errors++; $display("FAIL lat4_bin21 got=%0h want=fffffff1", gi[2].q[b2+21]); end
        checks++; if (gi[1].s_busy !== 1'b0 || gi[2].s_busy !== 1'b0) begin errors++; $display("FAIL lat_idle got=%b want=00", {gi[1].s_busy, gi[2].s_busy}); end
    endtask

    task automatic test_timeout();
        bit ok; int base;
        load_flat();
        mon_en = 1'b0;
        run_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_done got=0 want=1"); end
        checks++; if (gi[0].last_err_rise - gi[0].last_dv_fall != 64) begin errors++; $display("FAIL tmo_lat got=%0d want=64", gi[0].last_err_rise - gi[0].last_dv_fall); end
        checks++; if (gi[0].last_done != gi[0].last_err_rise) begin errors++; $display("FAIL tmo_done_cyc got=%0d want=%0d", gi[0].last_done, gi[0].last_err_rise); end
        checks++; if ({gi[0].s_err, gi[0].s_en} !== 2'b10) begin errors++; $display("FAIL tmo_flags got=%b want=10", {gi[0].s_err, gi[0].s_en}); end
        mon_en = 1'b1;
        base = gi[0].q.size();
        run_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_next_done got=0 want=1"); end
        checks++; if (gi[0].s_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%0b want=1", gi[0].s_err); end
        checks++; if (gi[0].last_done - gi[0].last_dv_fall != 3) begin errors++; $display("FAIL tmo_next_lat got=%0d want=3", gi[0].last_done - gi[0].last_dv_fall); end
        checks++; if (gi[0].q[base+20] !== 32'd20) begin errors++; $display("FAIL tmo_next_bin20 got=%0d want=20", gi[0].q[base+20]); end
    endtask

    task automatic test_busy_stray();
        bit ok = 1'b0; bit hit = 1'b0; int base; int nd0; logic [31:0] exp;
        for (int i = 0; i < 64; i++) mem[i] = (i < 16) ? 32'd50 : 32'(50 + 3 * i);
        base = gi[0].q.size(); nd0 = gi[0].n_done;
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0; stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gi[0].s_dv) begin hit = 1'b1; break; end
        end
        checks++; if (!hit || gi[0].s_busy !== 1'b1) begin errors++; $display("FAIL stray_stream got=%b want=11", {hit, gi[0].s_busy}); end
        start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (gi[0].s_done) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL stray_done got=0 want=1"); end
        checks++; if (gi[0].n_done - nd0 != 1) begin errors++; $display("FAIL stray_done_cnt got=%0d want=1", gi[0].n_done - nd0); end
        checks++; if (gi[0].last_done - gi[0].last_dv_fall != 3) begin errors++; $display("FAIL stray_done_lat got=%0d want=3", gi[0].last_done - gi[0].last_dv_fall); end
        checks++; if (gi[0].s_bg !== 32'd50) begin errors++; $display("FAIL stray_bg got=%0d want=50", gi[0].s_bg); end
        checks++; if (gi[0].last_run_len != 64 || gi[0].q.size() - base != 64) begin errors++; $display("FAIL stray_count got=%0d want=64", gi[0].q.size() - base); end
        for (int i = 0; i < 64; i++) begin
            exp = (i < 16) ? 32'd0 : 32'(3 * i);
            checks++;
            if (gi[0].q[base+i] !== exp) begin errors++; $display("FAIL stray_bin%0d got=%0d want=%0d", i, gi[0].q[base+i], exp); end
        end
        checks++; if (gi[0].s_busy !== 1'b0) begin errors++; $display("FAIL stray_idle got=%0b want=0", gi[0].s_busy); end
    endtask

    task automatic test_reset_mid();
        bit ok; bit hit = 1'b0; int base; logic [31:0] exp;
        load_flat();
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gi[0].s_en && gi[0].s_rd_en && gi[0].s_rd_addr == 9'd30) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach got=0 want=1"); end
        rst = 1'b1;
        #1;
        checks++; if ({gi[0].s_rd_en, gi[0].s_dv, gi[0].s_en, gi[0].s_busy} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctl got=%b want=0000", {gi[0].s_rd_en, gi[0].s_dv, gi[0].s_en, gi[0].s_busy}); end
        checks++; if (gi[0].s_dout !== 32'd0 || gi[0].s_bg !== 32'd0 || gi[0].s_rd_addr !== 9'd0) begin errors++; $display("FAIL rstmid_data got=%0h/%0h/%0h want=0", gi[0].s_dout, gi[0].s_bg, gi[0].s_rd_addr); end
        checks++; if (gi[0].s_err !== 1'b0 || gi[0].s_done !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b want=00", {gi[0].s_err, gi[0].s_done}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        base = gi[0].q.size();
        run_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_done got=0 want=1"); end
        checks++; if (gi[0].q.size() - base != 64 || gi[0].last_run_len != 64) begin errors++; $display("FAIL rstmid_count got=%0d want=64", gi[0].q.size() - base); end
        checks++; if (gi[0].s_bg !== 32'd100) begin errors++; $display("FAIL rstmid_bg got=%0d want=100", gi[0].s_bg); end
        for (int i = 0; i < 64; i++) begin
            exp = (i < 16) ? 32'd0 : 32'(i);
            checks++;
            if (gi[0].q[base+i] !== exp) begin errors++; $display("FAIL rstmid_bin%0d got=%0d want=%0d", i, gi[0].q[base+i], exp); end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_saturation();
        test_latency();
        test_timeout();
        test_busy_stray();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
